// File: rtl/io_timer_bank.sv
// Bank of CTimerCnt prescaled down-counting timers on the processor IO space.
// Writes land at the end of the request cycle; reads stall one cycle and return data the next.
module io_timer_bank #(
    parameter int          CTimerCnt = 4,
    parameter logic [15:0] CBaseAddr = 16'h0100
) (
    input  logic                 AClkH,
    input  logic                 AResetH,
    input  logic                 AClkHEn,
    input  logic [15:0]          AIoSpaceAddr,
    input  logic [63:0]          AIoSpaceMosi,
    input  logic [3:0]           AIoSpaceWrSize,
    input  logic [3:0]           AIoSpaceRdSize,
    output logic [63:0]          AIoSpaceMiso,
    output logic                 AIoSpaceBusy,
    output logic [CTimerCnt-1:0] AIrq
);
    // state  | meaning
    // S_IDLE | En=0, counter and prescaler frozen
    // S_RUN  | En=1, prescaler running, COUNT decrements on each tick
    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_RUN     = 1'b1;
    localparam logic [31:0] CWinBytes = 32'(16 * CTimerCnt);

    logic [0:0]           r_state  [CTimerCnt];
    logic [7:0]           r_psc    [CTimerCnt];
    logic [7:0]           r_pcnt   [CTimerCnt];
    logic [31:0]          r_reload [CTimerCnt];
    logic [31:0]          r_count  [CTimerCnt];
    logic [CTimerCnt-1:0] r_per;
    logic [CTimerCnt-1:0] r_irqen;
    logic [CTimerCnt-1:0] r_exp;
    logic [CTimerCnt-1:0] r_irq;
    logic [63:0]          r_miso;

    logic [15:0]          w_off;
    logic [3:0]           w_idx;
    logic [1:0]           w_reg;
    logic                 w_in_win;
    logic                 w_wr_hit;
    logic                 w_rd_hit;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rdata;
    logic [CTimerCnt-1:0] w_wr_sel;
    logic [CTimerCnt-1:0] w_tick;
    logic                 w_unused;

    assign w_off    = AIoSpaceAddr - CBaseAddr;
    assign w_idx    = w_off[7:4];
    assign w_reg    = w_off[3:2];
    assign w_in_win = (AIoSpaceAddr >= CBaseAddr) && ({16'd0, w_off} < CWinBytes)
                      && (AIoSpaceAddr[1:0] == 2'b00);
    assign w_wr_hit = w_in_win && (AIoSpaceWrSize == 4'd4);
    // A hit write swallows any simultaneous read.
    assign w_rd_hit = w_in_win && (AIoSpaceRdSize == 4'd4) && (AIoSpaceWrSize == 4'd0);
    assign w_wdata  = AIoSpaceMosi[31:0];
    assign w_unused = ^AIoSpaceMosi[63:32];

    assign AIoSpaceBusy = AClkHEn && !AResetH && w_rd_hit;
    assign AIoSpaceMiso = r_miso;
    assign AIrq         = r_irq;

    always_comb begin
        w_wr_sel = '0;
        w_tick   = '0;
        for (int i = 0; i < CTimerCnt; i++) begin
            w_wr_sel[i] = w_wr_hit && (w_idx == 4'(i));
            w_tick[i]   = (r_state[i] == S_RUN) && (r_pcnt[i] >= r_psc[i]);
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < CTimerCnt; i++) begin
            if (w_idx == 4'(i)) begin
                case (w_reg)
                    2'd0:    w_rdata = {16'd0, r_psc[i], 5'd0, r_irqen[i], r_per[i],
                                        r_state[i] == S_RUN};
                    2'd1:    w_rdata = r_reload[i];
                    2'd2:    w_rdata = r_count[i];
                    default: w_rdata = {31'd0, r_exp[i]};
                endcase
            end
        end
    end

    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            for (int i = 0; i < CTimerCnt; i++) begin
                r_state[i]  <= S_IDLE;
                r_psc[i]    <= '0;
                r_pcnt[i]   <= '0;
                r_reload[i] <= '0;
                r_count[i]  <= '0;
            end
            r_per   <= '0;
            r_irqen <= '0;
            r_exp   <= '0;
            r_irq   <= '0;
            r_miso  <= '0;
        end else if (AClkHEn) begin
            r_miso <= w_rd_hit ? {32'd0, w_rdata} : 64'd0;
            for (int i = 0; i < CTimerCnt; i++) begin
                // Clear before the timer update so a same-cycle expiry wins.
                if (w_wr_sel[i] && (w_reg == 2'd3) && w_wdata[0])
                    r_exp[i] <= 1'b0;
                if (r_state[i] == S_RUN) begin
                    r_pcnt[i] <= w_tick[i] ? 8'd0 : r_pcnt[i] + 8'd1;
                    if (w_tick[i]) begin
                        if (r_count[i] != 32'd0) begin
                            r_count[i] <= r_count[i] - 32'd1;
                        end else begin
                            r_exp[i] <= 1'b1;
                            if (r_per[i])
                                r_count[i] <= r_reload[i];
                            else
                                r_state[i] <= S_IDLE;
                        end
                    end
                end
                // Bus writes come last so they override the timer update.
                if (w_wr_sel[i]) begin
                    case (w_reg)
                        2'd0: begin
                            r_per[i]   <= w_wdata[1];
                            r_irqen[i] <= w_wdata[2];
                            r_psc[i]   <= w_wdata[15:8];
                            if (!w_wdata[0]) begin
                                r_state[i] <= S_IDLE;
                                r_pcnt[i]  <= 8'd0;
                            end else if (r_state[i] == S_IDLE) begin
                                r_state[i] <= S_RUN;
                                r_pcnt[i]  <= 8'd0;
                            end
                        end
                        2'd1: r_reload[i] <= w_wdata;
                        2'd2: begin
                            r_count[i] <= w_wdata;
                            r_pcnt[i]  <= 8'd0;
                        end
                        default: ;
                    endcase
                end
                r_irq[i] <= r_exp[i] & r_irqen[i];
            end
        end
    end
endmodule

// File: tb/tb_io_timer_bank.sv
// Directed bench for io_timer_bank: bus decode, read handshake, timer timing,
// simultaneous-event priorities, clock-enable hold and asynchronous reset.
module tb_io_timer_bank;
    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] addr;
    logic [63:0] mosi;
    logic [3:0]  wrsize;
    logic [3:0]  rdsize;
    logic [63:0] miso;
    logic        bsy;
    logic [3:0]  irq;

    int n_vec = 0;
    int n_err = 0;

    io_timer_bank #(.CTimerCnt(4), .CBaseAddr(16'h0100)) dut (
        .AClkH          (clk),
        .AResetH        (rst),
        .AClkHEn        (en),
        .AIoSpaceAddr   (addr),
        .AIoSpaceMosi   (mosi),
        .AIoSpaceWrSize (wrsize),
        .AIoSpaceRdSize (rdsize),
        .AIoSpaceMiso   (miso),
        .AIoSpaceBusy   (bsy),
        .AIrq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] sz);
        addr   = a;
        mosi   = {32'hA5A5_A5A5, d};
        wrsize = sz;
        rdsize = 4'd0;
        @(negedge clk);
        wrsize = 4'd0;
        addr   = 16'd0;
        mosi   = 64'd0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [3:0] sz,
                      output logic b, output logic [63:0] d);
        addr   = a;
        rdsize = sz;
        wrsize = 4'd0;
        #1 b = bsy;
        @(negedge clk);
        rdsize = 4'd0;
        addr   = 16'd0;
        #1 d = miso;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [63:0] expd);
        logic        b;
        logic [63:0] d;
        rd(a, 4'd4, b, d);
        chk({tag, "_busy"}, 64'(b), 64'd1);
        chk(tag, d, expd);
    endtask

    task automatic ign_rd(input string tag, input logic [15:0] a, input logic [3:0] sz);
        logic        b;
        logic [63:0] d;
        rd(a, sz, b, d);
        chk({tag, "_busy"}, 64'(b), 64'd0);
        chk({tag, "_miso"}, d, 64'd0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; addr = '0; mosi = '0; wrsize = '0; rdsize = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_miso", miso, 64'd0);
        chk("rst_busy", 64'(bsy), 64'd0);
        chk("rst_irq", 64'(irq), 64'd0);
        rd_chk("rst_ctrl0", 16'h0100, 64'd0);

        // Timer 0: periodic, Psc=0, COUNT=RELOAD=3 -> expiry every 4 cycles.
        wr(16'h0104, 32'd3, 4'd4);
        wr(16'h0108, 32'd3, 4'd4);
        wr(16'h0100, 32'h0007, 4'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("t0_irq_c%0d", k), 64'(irq[0]), (k >= 5) ? 64'd1 : 64'd0);
        end
        rd_chk("t0_reload_count", 16'h0108, 64'd3);
        wr(16'h010C, 32'd1, 4'd4);
        chk("t0_irq_after_w1c", 64'(irq[0]), 64'd1);
        @(negedge clk);
        chk("t0_irq_fall", 64'(irq[0]), 64'd0);
        @(negedge clk);
        chk("t0_irq_low", 64'(irq[0]), 64'd0);
        @(negedge clk);
        chk("t0_irq_rerise", 64'(irq[0]), 64'd1);
        repeat (2) @(negedge clk);
        wr(16'h010C, 32'd1, 4'd4);
        rd_chk("t0_w1c_vs_expiry", 16'h010C, 64'd1);
        wr(16'h0100, 32'd0, 4'd4);
        wr(16'h010C, 32'd1, 4'd4);
        rd_chk("t0_frozen_count", 16'h0108, 64'd1);

        // Timer 1: one-shot, Psc=4, COUNT=2 -> expiry on the 15th cycle.
        wr(16'h0118, 32'd2, 4'd4);
        wr(16'h0110, 32'h0405, 4'd4);
        repeat (15) @(negedge clk);
        chk("t1_irq_c15", 64'(irq), 64'h0);
        @(negedge clk);
        chk("t1_irq_c16", 64'(irq), 64'h2);
        rd_chk("t1_ctrl_en_clr", 16'h0110, 64'h0404);
        rd_chk("t1_count_zero", 16'h0118, 64'd0);
        repeat (10) @(negedge clk);
        rd_chk("t1_count_still0", 16'h0118, 64'd0);
        rd_chk("t1_status", 16'h011C, 64'd1);

        // Timer 2: Psc=1, COUNT write lands on a tick.
        wr(16'h0128, 32'd50, 4'd4);
        wr(16'h0120, 32'h0101, 4'd4);
        repeat (3) @(negedge clk);
        wr(16'h0128, 32'd10, 4'd4);
        rd_chk("t2_write_beats_tick", 16'h0128, 64'd10);
        wr(16'h0120, 32'd0, 4'd4);

        // Ignored accesses.
        ign_rd("ign_rd8", 16'h0100, 4'd8);
        ign_rd("ign_misalign", 16'h0102, 4'd4);
        ign_rd("ign_past_end", 16'h0140, 4'd4);
        wr(16'h0104, 32'hDEAD, 4'd8);
        wr(16'h0106, 32'hBEEF, 4'd4);
        wr(16'h0140, 32'h1234, 4'd4);
        rd_chk("ign_reload_kept", 16'h0104, 64'd3);

        // Write and read together: write performed, read dropped.
        addr = 16'h0134; mosi = 64'h55; wrsize = 4'd4; rdsize = 4'd4;
        #1 chk("wrrd_busy", 64'(bsy), 64'd0);
        @(negedge clk);
        wrsize = 4'd0; rdsize = 4'd0; addr = '0; mosi = '0;
        #1 chk("wrrd_miso", miso, 64'd0);
        rd_chk("wrrd_reload", 16'h0134, 64'h55);

        // Timer 3: Psc=2, COUNT=100, clock enable dropped with a read in flight.
        wr(16'h0138, 32'd100, 4'd4);
        wr(16'h0130, 32'h0201, 4'd4);
        repeat (4) @(negedge clk);
        addr = 16'h0138; rdsize = 4'd4;
        #1 chk("clken_rd_busy", 64'(bsy), 64'd1);
        @(negedge clk);
        rdsize = 4'd0; addr = '0; en = 1'b0;
        #1 chk("clken_rd_data", miso, 64'd99);
        repeat (2) @(negedge clk);
        addr = 16'h0134; rdsize = 4'd4;
        #1 chk("clken_off_busy", 64'(bsy), 64'd0);
        @(negedge clk);
        rdsize = 4'd0; addr = '0;
        #1 chk("clken_off_miso_hold", miso, 64'd99);
        repeat (2) @(negedge clk);
        chk("clken_off_miso_hold2", miso, 64'd99);
        en = 1'b1;
        addr = 16'h0138; rdsize = 4'd4;
        #1;
        @(negedge clk);
        rdsize = 4'd0; addr = '0;
        #1 chk("clken_count_frozen", miso, 64'd99);
        rd_chk("clken_psc_resumed", 16'h0138, 64'd98);

        // Reset in the data cycle of a read.
        addr = 16'h0134; rdsize = 4'd4;
        @(posedge clk);
        #1;
        rdsize = 4'd0; addr = '0;
        chk("rst_pre_miso", miso, 64'h55);
        chk("rst_pre_irq", 64'(irq), 64'h2);
        rst = 1'b1;
        #1;
        chk("rst_mid_miso", miso, 64'd0);
        chk("rst_mid_irq", 64'(irq), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("rst_reload3", 16'h0134, 64'd0);
        rd_chk("rst_ctrl3", 16'h0130, 64'd0);
        rd_chk("rst_count0", 16'h0108, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
